// File: rtl/pkts_rx_buffer.sv
// Store-and-forward packet buffer: packets reach egress only once their last
// word is in; a packet longer than the buffer is discarded and flagged by drop.
module pkts_rx_buffer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         in_tdata,
  input  logic                     in_tlast,
  input  logic                     in_tvalid,
  output logic                     in_tready,
  output logic [WIDTH-1:0]         out_tdata,
  output logic                     out_tlast,
  output logic                     out_tvalid,
  input  logic                     out_tready,
  output logic                     drop,
  output logic [$clog2(DEPTH):0]   pkt_count
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned PTR_W  = ADDR_W + 1;

  typedef enum logic {RECV, DROP} state_t;

  state_t             state, state_next;
  logic [PTR_W-1:0]   wr_ptr, commit_ptr, rd_ptr;
  logic [PTR_W-1:0]   wr_next, commit_next;
  logic               drop_next;
  logic               ready_en;
  logic               wr_en;
  logic               full;
  logic               rd_fire;
  logic               commit_evt;
  logic               last_rd;
  logic [WIDTH:0]     mem [DEPTH];
  logic [WIDTH:0]     rd_word;

  // Egress view: head entry at rd_ptr, valid whenever committed data is waiting.
  assign full       = (wr_ptr - rd_ptr) == PTR_W'(DEPTH);
  assign rd_word    = mem[rd_ptr[ADDR_W-1:0]];
  assign out_tdata  = rd_word[WIDTH-1:0];
  assign out_tlast  = rd_word[WIDTH];
  assign out_tvalid = (rd_ptr != commit_ptr);
  assign rd_fire    = out_tvalid & out_tready;
  assign last_rd    = rd_fire & rd_word[WIDTH];
  assign commit_evt = wr_en & in_tlast;

  // Ingress FSM next-state, write pointer/commit control and handshake.
  always_comb begin
    state_next  = state;
    wr_next     = wr_ptr;
    commit_next = commit_ptr;
    drop_next   = 1'b0;
    wr_en       = 1'b0;
    in_tready   = 1'b0;
    case (state)
      RECV: begin
        if (!full) begin
          in_tready = ready_en;
          if (in_tvalid && ready_en) begin
            wr_en   = 1'b1;
            wr_next = wr_ptr + PTR_W'(1);
            if (in_tlast) commit_next = wr_ptr + PTR_W'(1);
          end
        end else if (commit_ptr == rd_ptr) begin
          // The partial packet alone fills the buffer: it can never fit.
          state_next = DROP;
          wr_next    = commit_ptr;
        end
      end
      DROP: begin
        in_tready = 1'b1;
        if (in_tvalid && in_tlast) begin
          drop_next  = 1'b1;
          state_next = RECV;
        end
      end
      default: state_next = RECV;
    endcase
  end

  // State, pointers, drop pulse and packet counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RECV;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      drop       <= 1'b0;
      ready_en   <= 1'b0;
      pkt_count  <= '0;
    end else begin
      state      <= state_next;
      wr_ptr     <= wr_next;
      commit_ptr <= commit_next;
      drop       <= drop_next;
      ready_en   <= 1'b1;
      if (rd_fire) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({commit_evt, last_rd})
        2'b10:   pkt_count <= pkt_count + PTR_W'(1);
        2'b01:   pkt_count <= pkt_count - PTR_W'(1);
        default: pkt_count <= pkt_count;
      endcase
    end
  end

  // Packet storage; contents survive reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[ADDR_W-1:0]] <= {in_tlast, in_tdata};
  end

endmodule

// File: tb/tb_pkts_rx_buffer.sv
// Bench for pkts_rx_buffer (DEPTH=4): packet-level model with a word
// scoreboard, a commit-based availability model and drop expectations.
module tb_pkts_rx_buffer;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] in_tdata;
  logic             in_tlast;
  logic             in_tvalid;
  logic             in_tready;
  logic [WIDTH-1:0] out_tdata;
  logic             out_tlast;
  logic             out_tvalid;
  logic             out_tready;
  logic             drop;
  logic [CW-1:0]    pkt_count;

  pkts_rx_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_tdata(in_tdata), .in_tlast(in_tlast), .in_tvalid(in_tvalid), .in_tready(in_tready),
    .out_tdata(out_tdata), .out_tlast(out_tlast), .out_tvalid(out_tvalid), .out_tready(out_tready),
    .drop(drop), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state
  logic [WIDTH:0] exp_q[$];
  int  avail;          // committed words not yet read
  int  good_in;        // complete good packets accepted
  int  good_out;       // good packets fully read
  int  cur_len;
  bit  cur_good;
  bit  exp_drop_next;
  int  exp_drops;
  int  seen_drops;
  bit  hold_valid;
  logic [WIDTH:0] held;
  bit  rdy_rand;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    avail = 0; good_in = 0; good_out = 0;
    exp_drop_next = 0; hold_valid = 0;
    cur_good = 1; cur_len = 0;
  endtask

  always @(posedge clk) cyc++;

  // Random egress backpressure when enabled.
  initial forever begin
    @(posedge clk); #1;
    if (rdy_rand) out_tready = 1'($urandom_range(0, 1));
  end

  // Monitor: compares DUT outputs against the model every cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("drop", 64'(drop), 64'(exp_drop_next));
      exp_drop_next = 0;
      if (drop) seen_drops++;
      chk("pkt_count", 64'(pkt_count), 64'(good_in - good_out));
      chk("out_tvalid", 64'(out_tvalid), 64'(avail > 0));
      if (hold_valid)
        chk("egress_stable", 64'({out_tvalid, out_tlast, out_tdata}), 64'({1'b1, held}));
      if (out_tvalid && out_tready) begin
        if (exp_q.size() == 0 || avail == 0) begin
          chk("unexpected_word", 64'({out_tlast, out_tdata}), 64'h0);
          n_fail += (exp_q.size() == 0 && {out_tlast, out_tdata} == '0) ? 1 : 0;
        end else begin
          logic [WIDTH:0] e;
          e = exp_q.pop_front();
          chk("egress_word", 64'({out_tlast, out_tdata}), 64'(e));
          avail--;
          if (e[WIDTH]) good_out++;
        end
      end
      hold_valid = out_tvalid && !out_tready;
      held = {out_tlast, out_tdata};
      if (in_tvalid && in_tready && in_tlast) begin
        if (cur_good) begin
          avail += cur_len;
          good_in++;
        end else begin
          exp_drop_next = 1;
        end
      end
    end
  end

  // Present one word and hold it until accepted (bounded).
  task automatic send_word(input logic [WIDTH-1:0] d, input logic last);
    bit hs;
    in_tvalid = 1'b1; in_tdata = d; in_tlast = last;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); hs = in_tready;
      @(posedge clk); #1;
      if (hs) return;
    end
    chk("ingress_timeout", 64'(0), 64'(1));
  endtask

  task automatic send_pkt(input int len, input bit gaps);
    logic [WIDTH-1:0] w[$];
    for (int i = 0; i < len; i++) w.push_back($urandom);
    cur_len  = len;
    cur_good = (len <= DEPTH);
    if (cur_good) for (int i = 0; i < len; i++) exp_q.push_back({i == len - 1, w[i]});
    else exp_drops++;
    for (int i = 0; i < len; i++) begin
      if (gaps) begin
        for (int g = 0; g < 4 && $urandom_range(0, 1) == 1; g++) begin
          in_tvalid = 1'b0; @(posedge clk); #1;
        end
      end
      send_word(w[i], i == len - 1);
    end
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 2000; i++) begin
      if (exp_q.size() == 0 && !out_tvalid) begin
        @(posedge clk); #1;
        chk("drain_pkt_count", 64'(pkt_count), 64'(0));
        return;
      end
      @(posedge clk); #1;
    end
    chk("drain_timeout", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    rst_n = 1'b0; in_tvalid = 0; in_tlast = 0; in_tdata = '0; out_tready = 0;
    rdy_rand = 0; exp_drops = 0; seen_drops = 0;
    clear_model();
    #2;
    chk("rst_in_tready", 64'(in_tready), 64'(0));
    chk("rst_out_tvalid", 64'(out_tvalid), 64'(0));
    chk("rst_pkt_count", 64'(pkt_count), 64'(0));
    chk("rst_drop", 64'(drop), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("pre_edge_in_tready", 64'(in_tready), 64'(0));
    @(posedge clk); #1;
    chk("post_rst_in_tready", 64'(in_tready), 64'(1));

    // 3-word packet, egress open; valid right after last word accepted
    out_tready = 1;
    send_pkt(3, 0);
    chk("latency_valid", 64'(out_tvalid), 64'(1));
    wait_drain();

    // 6-word oversize packet with egress blocked
    out_tready = 0;
    send_pkt(6, 0);
    repeat (3) @(posedge clk); #1;
    chk("oversize_no_valid", 64'(out_tvalid), 64'(0));
    chk("oversize_drops", 64'(seen_drops), 64'(exp_drops));

    // Two stored packets fill buffer; third waits for egress
    send_pkt(2, 0);
    send_pkt(2, 0);
    fork
      send_pkt(2, 0);
      begin
        repeat (5) @(negedge clk);
        chk("full_in_tready", 64'(in_tready), 64'(0));
        chk("full_pkt_count", 64'(pkt_count), 64'(2));
        @(posedge clk); #1 out_tready = 1;
      end
    join
    wait_drain();

    // Back-to-back single-word packets at full rate
    begin
      int t0;
      t0 = cyc;
      for (int k = 0; k < 20; k++) send_pkt(1, 0);
      chk("stream_cycles", 64'(cyc - t0), 64'(20));
      wait_drain();
    end

    // Reset mid-packet: two of three A words written
    out_tready = 0;
    cur_len = 3; cur_good = 1;
    send_word(32'hA1, 0);
    send_word(32'hA2, 0);
    in_tvalid = 0;
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_in_tready", 64'(in_tready), 64'(0));
    chk("midrst_out_tvalid", 64'(out_tvalid), 64'(0));
    chk("midrst_pkt_count", 64'(pkt_count), 64'(0));
    clear_model();
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    out_tready = 1;
    send_pkt(1, 0);
    wait_drain();

    // Random traffic with random backpressure and lengths 1..DEPTH+2
    rdy_rand = 1;
    for (int k = 0; k < 60; k++) send_pkt($urandom_range(1, DEPTH + 2), 1);
    rdy_rand = 0;
    @(posedge clk); #1 out_tready = 1;
    wait_drain();
    repeat (3) @(posedge clk); #1;
    chk("total_drops", 64'(seen_drops), 64'(exp_drops));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pkts_rx_buffer.md
PKTS_RX_BUFFER -- requirements
Module: pkts_rx_buffer

Interface
REQ-001 Parameter WIDTH, default 32: tdata width in bits, both ports.
REQ-002 Parameter DEPTH, default 16: buffer capacity in words; power of two, >= 2.
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_tdata  input  WIDTH  ingress packet word.
REQ-006 in_tlast  input  1  ingress last word of packet.
REQ-007 in_tvalid  input  1  ingress word valid.
REQ-008 in_tready  output  1  ingress word accepted when high with in_tvalid.
REQ-009 out_tdata  output  WIDTH  egress packet word.
REQ-010 out_tlast  output  1  egress last word of packet.
REQ-011 out_tvalid  output  1  egress word valid.
REQ-012 out_tready  input  1  egress word consumed when high with out_tvalid.
REQ-013 drop  output  1  one-cycle pulse, oversize packet discarded.
REQ-014 pkt_count  output  $clog2(DEPTH)+1  complete packets held, not yet fully read.

Function
REQ-015 Store-and-forward: no word of a packet appears on egress before its tlast word is accepted on ingress.
REQ-016 Storage: DEPTH entries of {tlast, tdata}; pointers wr_ptr, commit_ptr, rd_ptr, each $clog2(DEPTH)+1 bits, wrapping modulo 2*DEPTH.
REQ-017 Full: wr_ptr - rd_ptr == DEPTH; egress empty: rd_ptr == commit_ptr.
REQ-018 Ingress state machine states: RECV, DROP; reset state RECV.
REQ-019 RECV, not full: in_tready = 1; each accepted word written at wr_ptr, wr_ptr increments.
REQ-020 RECV, accepted word with in_tlast = 1: commit_ptr <= wr_ptr + 1 same edge.
REQ-021 RECV, full, commit_ptr != rd_ptr: in_tready = 0 until egress frees an entry.
REQ-022 RECV, full, commit_ptr == rd_ptr (packet exceeds DEPTH): next state DROP, wr_ptr <= commit_ptr.
REQ-023 DROP: in_tready = 1, accepted words discarded, no pointer change.
REQ-024 DROP, accepted word with in_tlast = 1: drop pulses high next cycle, next state RECV.
REQ-025 out_tvalid = 1 when egress not empty; out_tdata/out_tlast = entry at rd_ptr.
REQ-026 Egress handshake: rd_ptr increments on out_tvalid & out_tready; out_tdata/out_tlast stay stable while out_tvalid & !out_tready.
REQ-027 Latency: tlast accepted at edge N -> out_tvalid high from cycle after edge N (earliest 1 cycle).
REQ-028 Simultaneous ingress write and egress read in same cycle both proceed; full evaluated on pre-edge pointers.
REQ-029 pkt_count +1 on commit, -1 on egress accept of tlast word, unchanged when both occur same cycle.
REQ-030 Single-word packet (tlast on first word) handled as normal packet of length 1.
REQ-031 Egress never blocks ingress of a partial packet except per REQ-021.

Reset
REQ-032 rst_n low asynchronously forces: all pointers 0, state RECV, in_tready 0, out_tvalid 0, drop 0, pkt_count 0.
REQ-033 in_tready 1 from first rising edge after rst_n deasserts.
REQ-034 Reset mid-packet discards all stored and partial data; storage contents need not be cleared.

Verification
REQ-035 DEPTH=4, send 3-word packet A1..A3, out_tready=1 -> out_tvalid cycle after A3 accepted, A1..A3 emitted, out_tlast on A3, pkt_count 1 -> 0.
REQ-036 DEPTH=4, send 6-word packet, out_tready=0 -> after 4 words state DROP, remaining 2 accepted, drop pulses once, out_tvalid stays 0, pkt_count 0.
REQ-037 DEPTH=4, two 2-word packets stored, out_tready=0, third packet offered -> in_tready 0; raise out_tready -> drain first packet, third accepted, order preserved.
REQ-038 Continuous 1-word packets, in_tvalid=out_tready=1 -> one word per cycle throughput after 1-cycle latency, pkt_count alternates 1 steady.
REQ-039 rst_n low mid-packet (2 of 3 words written) -> outputs reset immediately; post-reset new packet B1 emitted alone, no A words.
REQ-040 Random in_tvalid/out_tready (50%), random lengths 1..DEPTH+2 -> scoreboard: all packets <= DEPTH delivered intact in order, one drop per oversize packet.
